sensor_frame_feeder: RTL and testbench

//  Front end that builds frames for the glove classifier core. Parses a byte

---
 rtl/sensor_frame_feeder.sv | 131 +++++++++++++
 tb/tb_sensor_frame_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_feeder.sv
// Byte-stream frame parser feeding the classifier core: sync, LSB-first 16-bit samples, XOR checksum.
// Latency: checksum byte to o_next is 1 cycle; RX keeps assembling while TX holds o_data awaiting ack/timeout.
module sensor_frame_feeder #(
  parameter int         N_SAMPLES   = 40,
  parameter int         SAMPLE_W    = 16,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         ACK_TIMEOUT = 4096
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_byte_valid,
  input  logic [7:0]                             i_byte,
  input  logic                                   i_ack,
  output logic [0:N_SAMPLES-1][SAMPLE_W-1:0]     o_data,
  output logic                                   o_next,
  output logic                                   o_busy,
  output logic                                   o_chk_err,
  output logic                                   o_overrun,
  output logic                                   o_timeout,
  output logic [15:0]                            o_frame_count
);

  localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_CHK  = 2'd3;

  localparam logic [0:0] T_IDLE = 1'b0;
  localparam logic [0:0] T_WAIT = 1'b1;

  logic [1:0]                               rx_state;
  logic [IDX_W-1:0]                         idx;
  logic [7:0]                               chk;
  logic [7:0]                               lo;
  logic [0:N_SAMPLES-1][SAMPLE_W-1:0]       asm_buf;

  logic [0:0]                               tx_state;
  logic [TMR_W-1:0]                         timer;

  logic chk_byte;
  logic frame_good;
  logic frame_bad;

  assign chk_byte   = i_byte_valid && (rx_state == S_CHK);
  assign frame_good = chk_byte && (i_byte == chk);
  assign frame_bad  = chk_byte && (i_byte != chk);
  assign o_busy     = (tx_state == T_WAIT);

  // Receive side: sync byte only matters in S_SYNC, so A5 inside a payload is plain data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state <= S_SYNC;
      idx      <= '0;
      chk      <= '0;
      lo       <= '0;
      asm_buf  <= '0;
    end else if (i_byte_valid) begin
      case (rx_state)
        S_SYNC: begin
          if (i_byte == SYNC_BYTE) begin
            rx_state <= S_LO;
            idx      <= '0;
            chk      <= '0;
          end
        end
        S_LO: begin
          lo       <= i_byte;
          chk      <= chk ^ i_byte;
          rx_state <= S_HI;
        end
        S_HI: begin
          asm_buf[idx] <= {i_byte, lo};
          chk          <= chk ^ i_byte;
          if (idx == IDX_LAST) begin
            rx_state <= S_CHK;
          end else begin
            idx      <= idx + 1'b1;
            rx_state <= S_LO;
          end
        end
        default: rx_state <= S_SYNC;
      endcase
    end
  end

  // Transmit side: an ack in the same cycle as a good frame frees the slot first, so the frame is issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state      <= T_IDLE;
      timer         <= '0;
      o_data        <= '0;
      o_next        <= 1'b0;
      o_chk_err     <= 1'b0;
      o_overrun     <= 1'b0;
      o_timeout     <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_next    <= 1'b0;
      o_overrun <= 1'b0;
      o_timeout <= 1'b0;
      o_chk_err <= frame_bad;
      if (frame_good && (tx_state == T_IDLE || i_ack)) begin
        o_data        <= asm_buf;
        o_next        <= 1'b1;
        o_frame_count <= o_frame_count + 16'd1;
        timer         <= '0;
        tx_state      <= T_WAIT;
      end else if (tx_state == T_WAIT) begin
        if (i_ack) begin
          tx_state <= T_IDLE;
        end else begin
          if (frame_good) begin
            o_overrun <= 1'b1;
          end
          if (timer == TMR_LAST) begin
            o_timeout <= 1'b1;
            tx_state  <= T_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_frame_feeder.sv
// Directed bench for sensor_frame_feeder: a default-timeout instance plus a short-timeout instance on shared stimulus.
module tb_sensor_frame_feeder;

  typedef logic [0:39][15:0] frame_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        i_ack;

  frame_t      o_data;
  logic        o_next, o_busy, o_chk_err, o_overrun, o_timeout;
  logic [15:0] o_frame_count;

  frame_t      to_data;
  logic        to_next, to_busy, to_chk_err, to_overrun, to_timeout;
  logic [15:0] to_frame_count;

  int checks = 0;
  int errors = 0;

  sensor_frame_feeder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte_valid(i_byte_valid), .i_byte(i_byte), .i_ack(i_ack),
    .o_data(o_data), .o_next(o_next), .o_busy(o_busy), .o_chk_err(o_chk_err),
    .o_overrun(o_overrun), .o_timeout(o_timeout), .o_frame_count(o_frame_count)
  );

  sensor_frame_feeder #(.ACK_TIMEOUT(16)) dut_to (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_byte_valid(i_byte_valid), .i_byte(i_byte), .i_ack(i_ack),
    .o_data(to_data), .o_next(to_next), .o_busy(to_busy), .o_chk_err(to_chk_err),
    .o_overrun(to_overrun), .o_timeout(to_timeout), .o_frame_count(to_frame_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] xsum(input frame_t f);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 40; i++) x = x ^ f[i][7:0] ^ f[i][15:8];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    i_byte_valid = 1'b1;
    i_byte       = b;
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
  endtask

  task automatic send_body(input frame_t f);
    send_byte(8'hA5);
    for (int i = 0; i < 40; i++) begin
      send_byte(f[i][7:0]);
      send_byte(f[i][15:8]);
    end
  endtask

  task automatic pulse_ack();
    i_ack = 1'b1;
    @(negedge i_clk);
    i_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i_byte_valid = 1'b0; i_ack = 1'b0; i_byte = 8'h00;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", o_data); end
    checks++; if ({o_next, o_busy, o_chk_err, o_overrun, o_timeout} !== 5'b0) begin
      errors++; $display("FAIL rst_flags: got %b want 00000", {o_next, o_busy, o_chk_err, o_overrun, o_timeout}); end
    checks++; if (o_frame_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", o_frame_count); end
  endtask

  task automatic test_good_frame();
    frame_t f;
    for (int i = 0; i < 40; i++) f[i] = 16'(i);
    do_reset();
    send_body(f);
    checks++; if (o_next !== 1'b0) begin errors++; $display("FAIL t1_early_next: got %b want 0", o_next); end
    send_byte(xsum(f));
    checks++; if (o_next !== 1'b1) begin errors++; $display("FAIL t1_next: got %b want 1", o_next); end
    checks++; if (o_data !== f) begin errors++; $display("FAIL t1_data: got %h want %h", o_data, f); end
    checks++; if (o_frame_count !== 16'd1) begin errors++; $display("FAIL t1_count: got %0d want 1", o_frame_count); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", o_busy); end
    @(negedge i_clk);
    checks++; if (o_next !== 1'b0) begin errors++; $display("FAIL t1_next_pulse: got %b want 0", o_next); end
    pulse_ack();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL t1_ack_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_chk_err();
    frame_t f;
    for (int i = 0; i < 40; i++) f[i] = 16'(i);
    do_reset();
    send_body(f); send_byte(xsum(f));
    pulse_ack();
    send_body(f);
    send_byte(xsum(f) ^ 8'h01);
    checks++; if (o_chk_err !== 1'b1) begin errors++; $display("FAIL t2_chk_err: got %b want 1", o_chk_err); end
    checks++; if (o_next !== 1'b0) begin errors++; $display("FAIL t2_next: got %b want 0", o_next); end
    checks++; if (o_frame_count !== 16'd1) begin errors++; $display("FAIL t2_count: got %0d want 1", o_frame_count); end
    checks++; if (o_data !== f) begin errors++; $display("FAIL t2_data: got %h want %h", o_data, f); end
    @(negedge i_clk);
    checks++; if (o_chk_err !== 1'b0) begin errors++; $display("FAIL t2_chk_pulse: got %b want 0", o_chk_err); end
  endtask

  task automatic test_overrun();
    frame_t f1, f2, f3;
    for (int i = 0; i < 40; i++) begin
      f1[i] = 16'(i);
      f2[i] = 16'h1000 + 16'(i * 3);
      f3[i] = 16'hBEEF ^ 16'(i);
    end
    do_reset();
    send_body(f1); send_byte(xsum(f1));
    send_body(f2); send_byte(xsum(f2));
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL t3_overrun: got %b want 1", o_overrun); end
    checks++; if (o_next !== 1'b0) begin errors++; $display("FAIL t3_next: got %b want 0", o_next); end
    checks++; if (o_data !== f1) begin errors++; $display("FAIL t3_data_held: got %h want %h", o_data, f1); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL t3_busy: got %b want 1", o_busy); end
    pulse_ack();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL t3_ack_busy: got %b want 0", o_busy); end
    send_body(f3); send_byte(xsum(f3));
    checks++; if (o_next !== 1'b1) begin errors++; $display("FAIL t3_next3: got %b want 1", o_next); end
    checks++; if (o_data !== f3) begin errors++; $display("FAIL t3_data3: got %h want %h", o_data, f3); end
    checks++; if (o_frame_count !== 16'd2) begin errors++; $display("FAIL t3_count: got %0d want 2", o_frame_count); end
  endtask

  task automatic test_timeout();
    frame_t f;
    for (int i = 0; i < 40; i++) f[i] = 16'h0F00 + 16'(i);
    do_reset();
    send_body(f); send_byte(xsum(f));
    checks++; if (to_next !== 1'b1) begin errors++; $display("FAIL t4_next: got %b want 1", to_next); end
    repeat (15) @(negedge i_clk);
    checks++; if ({to_timeout, to_busy} !== 2'b01) begin
      errors++; $display("FAIL t4_pre_timeout: got timeout,busy=%b want 01", {to_timeout, to_busy}); end
    @(negedge i_clk);
    checks++; if ({to_timeout, to_busy} !== 2'b10) begin
      errors++; $display("FAIL t4_timeout: got timeout,busy=%b want 10", {to_timeout, to_busy}); end
    @(negedge i_clk);
    checks++; if (to_timeout !== 1'b0) begin errors++; $display("FAIL t4_timeout_pulse: got %b want 0", to_timeout); end
    send_body(f); send_byte(xsum(f));
    checks++; if ({to_next, to_overrun} !== 2'b10) begin
      errors++; $display("FAIL t4_reissue: got next,overrun=%b want 10", {to_next, to_overrun}); end
    checks++; if (to_frame_count !== 16'd2) begin errors++; $display("FAIL t4_count: got %0d want 2", to_frame_count); end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    for (int i = 0; i < 40; i++) begin
      f1[i] = {8'hA5, 8'(i)};
      f2[i] = {8'(i), 8'hA5};
    end
    do_reset();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA6);
    send_body(f1); send_byte(xsum(f1));
    checks++; if (o_next !== 1'b1) begin errors++; $display("FAIL t5_next: got %b want 1", o_next); end
    checks++; if (o_data !== f1) begin errors++; $display("FAIL t5_data: got %h want %h", o_data, f1); end
    send_body(f2);
    i_ack = 1'b1;
    send_byte(xsum(f2));
    i_ack = 1'b0;
    checks++; if ({o_next, o_overrun, o_busy} !== 3'b101) begin
      errors++; $display("FAIL t5_ack_chk: got next,overrun,busy=%b want 101", {o_next, o_overrun, o_busy}); end
    checks++; if (o_data !== f2) begin errors++; $display("FAIL t5_data2: got %h want %h", o_data, f2); end
    checks++; if (o_frame_count !== 16'd2) begin errors++; $display("FAIL t5_count: got %0d want 2", o_frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    frame_t f;
    for (int i = 0; i < 40; i++) f[i] = 16'h7700 ^ 16'(i * 5);
    do_reset();
    send_body(f); send_byte(xsum(f));
    send_byte(8'hA5);
    for (int i = 0; i < 15; i++) begin
      send_byte(f[i][7:0]);
      send_byte(f[i][15:8]);
    end
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_next, o_busy, o_chk_err, o_overrun, o_timeout} !== 5'b0) begin
      errors++; $display("FAIL t6_flags: got %b want 00000", {o_next, o_busy, o_chk_err, o_overrun, o_timeout}); end
    checks++; if (o_frame_count !== 16'd0) begin errors++; $display("FAIL t6_count_rst: got %0d want 0", o_frame_count); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL t6_data_rst: got %h want 0", o_data); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    send_body(f); send_byte(xsum(f));
    checks++; if (o_next !== 1'b1) begin errors++; $display("FAIL t6_next: got %b want 1", o_next); end
    checks++; if (o_frame_count !== 16'd1) begin errors++; $display("FAIL t6_count: got %0d want 1", o_frame_count); end
    checks++; if (o_data !== f) begin errors++; $display("FAIL t6_data: got %h want %h", o_data, f); end
  endtask

  initial begin
    i_rst_n = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00; i_ack = 1'b0;
    test_reset();
    test_good_frame();
    test_chk_err();
    test_overrun();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
